// File: rtl/apb_pkg.sv
// Shared definitions for the APB master bridge: FSM state encoding and the
// SPI-master register map it usually talks to.
package apb_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = IDLE,
    S_SETUP  = SETUP,
    S_ACCESS = ACCESS,
    S_RESP   = RESP
  } apb_state_e;

  localparam logic [7:0] SPI_REG_CMD   = 8'h00;
  localparam logic [7:0] SPI_REG_ADDR  = 8'h04;
  localparam logic [7:0] SPI_REG_LEN   = 8'h08;
  localparam logic [7:0] SPI_REG_WDATA = 8'h0c;
  localparam logic [7:0] SPI_REG_RDATA = 8'h10;
  localparam logic [7:0] SPI_REG_CTRL  = 8'h14;

endpackage

// File: rtl/apb_master_bridge.sv
// Request/response stream to APB3 initiator, one transfer in flight.
// Optional ACCESS watchdog enabled by defining APB_MASTER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | req_ready_o high, waiting for a request
// SETUP  | psel high for one cycle, penable low
// ACCESS | psel and penable high until pready (or watchdog expiry)
// RESP   | rsp_valid_o high until the consumer takes it
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              pclk_i,
  input  logic              prstn_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i
);

  apb_state_e        state_q;
  logic [ADDR_W-1:0] paddr_q;
  logic              pwrite_q;
  logic              psel_q;
  logic              penable_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_q;
`endif

  always_ff @(posedge pclk_i) begin
    if (!prstn_i) begin
      state_q     <= S_IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            paddr_q  <= {req_addr_i[ADDR_W-1:2], 2'b00};
            pwrite_q <= req_write_i;
            pwdata_q <= req_wdata_i;
            psel_q   <= 1'b1;
            state_q  <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= S_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          tmo_q     <= '0;
`endif
        end
        S_ACCESS: begin
          // pready wins over a watchdog expiry in the same cycle
          if (pready_i) begin
            rsp_rdata_q <= pwrite_q ? '0 : prdata_i;
            rsp_err_q   <= pslverr_i;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign paddr_o     = paddr_q;
  assign pwrite_o    = pwrite_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwdata_o    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed plus randomized bench for apb_master_bridge; also covers the
// APB_MASTER_TIMEOUT_EN build when that macro is defined.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        prstn;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic        pwrite, psel, penable, pready, pslverr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
    .pclk_i(clk), .prstn_i(prstn),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err),
    .paddr_o(paddr), .pwrite_o(pwrite), .psel_o(psel), .penable_o(penable),
    .pwdata_o(pwdata), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transfer. The expected response follows the APB rules:
  // reads return the data present when pready is high, writes return zero,
  // error is pslverr at completion; wait cycles carry garbage that must be ignored.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input int waits, input logic [31:0] rd, input logic err,
                      input int rsp_delay, input logic hold_valid);
    logic [31:0] exp_addr, exp_rdata;
    exp_addr  = {addr[31:2], 2'b00};
    exp_rdata = wr ? 32'h0 : rd;
    check("idle_req_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    pready = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    check("setup_psel", {30'b0, psel, penable}, 32'd2);
    check("setup_paddr", paddr, exp_addr);
    check("setup_pwrite", {31'b0, pwrite}, {31'b0, wr});
    check("setup_pwdata", pwdata, wd);
    check("setup_req_ready", {31'b0, req_ready}, 32'd0);
    check("setup_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    req_valid = hold_valid;
    req_write = $urandom_range(0, 1);
    req_addr  = $urandom;
    req_wdata = $urandom;
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      check("access_psel", {30'b0, psel, penable}, 32'd3);
      check("access_paddr", paddr, exp_addr);
      check("access_pwrite", {31'b0, pwrite}, {31'b0, wr});
      check("access_pwdata", pwdata, wd);
      check("access_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      pready  = (i == waits);
      prdata  = (i == waits) ? rd : $urandom;
      pslverr = (i == waits) ? err : 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
    for (int d = 0; d <= rsp_delay; d++) begin
      check("resp_valid", {31'b0, rsp_valid}, 32'd1);
      check("resp_rdata", rsp_rdata, exp_rdata);
      check("resp_err", {31'b0, rsp_err}, {31'b0, err});
      check("resp_bus_idle", {30'b0, psel, penable}, 32'd0);
      check("resp_req_ready", {31'b0, req_ready}, 32'd0);
      if (d == rsp_delay) rsp_ready = 1'b1;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("post_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("post_psel", {31'b0, psel}, 32'd0);
  endtask

  // Start a read and leave it parked in ACCESS with pready low.
  task automatic start_stall(input logic [31:0] addr);
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_wdata = 32'h0;
    pready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    prstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; prdata = 32'hffff_ffff; pready = 1'b1; pslverr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_bus", {29'b0, psel, penable, pwrite}, 32'd0);
    check("rst_rsp", {30'b0, rsp_valid, rsp_err}, 32'd0);
    check("rst_paddr", paddr, 32'h0);
    check("rst_pwdata", pwdata, 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    prstn = 1'b1; pready = 1'b0; pslverr = 1'b0;
    @(negedge clk);
    check("rel_req_ready", {31'b0, req_ready}, 32'd1);

    xfer(1'b1, 32'h14, 32'h0000_0401, 0, 32'h1234_5678, 1'b0, 0, 1'b0);
    xfer(1'b0, 32'h10, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
    xfer(1'b0, 32'h10, 32'h0, 0, 32'hDEAD_BEEF, 1'b1, 0, 1'b0);
    xfer(1'b0, 32'h00, 32'h0, 3, 32'hCAFE_0001, 1'b0, 0, 1'b0);
    xfer(1'b1, 32'h0f, 32'hA5A5_5A5A, 1, 32'h0, 1'b0, 5, 1'b1);
    xfer(1'b0, 32'h08, 32'h0, 0, 32'h0000_00FF, 1'b0, 0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      xfer(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 3),
           $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
           1'($urandom_range(0, 1)));
    end

`ifdef APB_MASTER_TIMEOUT_EN
    start_stall(32'h0c);
    prdata = 32'h5555_AAAA;
    for (int i = 0; i < TMO; i++) begin
      check("tmo_access", {30'b0, psel, penable}, 32'd3);
      check("tmo_no_rsp", {31'b0, rsp_valid}, 32'd0);
      @(negedge clk);
    end
    check("tmo_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("tmo_rsp_err", {31'b0, rsp_err}, 32'd1);
    check("tmo_rsp_rdata", rsp_rdata, 32'h0);
    check("tmo_bus_idle", {30'b0, psel, penable}, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("tmo_idle", {31'b0, req_ready}, 32'd1);
`else
    start_stall(32'h0c);
    for (int i = 0; i < 100; i++) @(negedge clk);
    check("hang_access", {30'b0, psel, penable}, 32'd3);
    check("hang_no_rsp", {31'b0, rsp_valid}, 32'd0);
    prstn = 1'b0;
    @(negedge clk);
    prstn = 1'b1;
    @(negedge clk);
`endif

    start_stall(32'h04);
    @(negedge clk);
    prstn = 1'b0;
    pready = 1'b1; prdata = 32'h7777_7777;
    @(negedge clk);
    prstn = 1'b1;
    check("mid_rst_bus", {30'b0, psel, penable}, 32'd0);
    check("mid_rst_rsp", {31'b0, rsp_valid}, 32'd0);
    check("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    check("mid_rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
    check("mid_rst_no_psel", {31'b0, psel}, 32'd0);
    pready = 1'b0;

    xfer(1'b0, {24'h0, SPI_REG_RDATA}, 32'h0, 2, 32'h0BAD_F00D, 1'b0, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
